// File: rtl/fetch_unit_if.sv
// Fetch-to-decode handshake bundle.
// Carries the head-of-buffer word and its address.
interface fetch_unit_if #(
   parameter int ADDR_W = 10,
   parameter int INST_W = 20
);
   logic              out_valid;
   logic              out_ready;
   logic [INST_W-1:0] out_inst;
   logic [ADDR_W-1:0] out_pc;

   modport master (
      output out_valid,
      output out_inst,
      output out_pc,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_inst,
      input  out_pc,
      output out_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the memory PC port and buffers
// fetched {pc, inst} pairs in a small FIFO toward decode.
module fetch_unit #(
   parameter int ADDR_W    = 10,
   parameter int INST_W    = 20,
   parameter int RESET_PC  = 0,
   parameter int BUF_DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   output logic [ADDR_W-1:0]            pc,
   input  logic [INST_W-1:0]            inst_in,
   input  logic                         redirect,
   input  logic [ADDR_W-1:0]            redirect_pc,
   input  logic                         halt,
   fetch_unit_if.master                 dec,
   output logic [$clog2(BUF_DEPTH):0]   level
);

   localparam int PW = $clog2(BUF_DEPTH);
   localparam int LW = PW + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } entry_t;

   entry_t          fifo_q [BUF_DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic            push;
   logic            pop;
   logic            has_room;
   entry_t          head;

   assign has_room = (level < LW'(BUF_DEPTH));
   assign pop  = dec.out_valid & dec.out_ready;
   assign push = ~redirect & ~halt & (has_room | pop);

   assign head          = fifo_q[rd_ptr];
   assign dec.out_valid = (level != '0);
   assign dec.out_inst  = dec.out_valid ? head.inst : '0;
   assign dec.out_pc    = dec.out_valid ? head.pc : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc     <= ADDR_W'(RESET_PC);
         level  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (redirect) begin
         // Flush; a same-cycle pop is treated as taken by decode.
         pc     <= redirect_pc;
         level  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) begin
            pc     <= pc + ADDR_W'(1);
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else if (push) begin
         fifo_q[wr_ptr] <= '{pc: pc, inst: inst_in};
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus
// hand sequences for reset, back-pressure and async reset.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic [9:0]  pc;
   logic [19:0] inst_in;
   logic        redirect;
   logic [9:0]  redirect_pc;
   logic        halt;
   logic [1:0]  level;

   int checks;
   int errors;

   logic [19:0] mem [1024];

   fetch_unit_if #(.ADDR_W(10), .INST_W(20)) dec_if ();

   fetch_unit #(
      .ADDR_W(10),
      .INST_W(20),
      .RESET_PC(0),
      .BUF_DEPTH(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .pc(pc),
      .inst_in(inst_in),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
      .halt(halt),
      .dec(dec_if.master),
      .level(level)
   );

   assign inst_in = mem[pc];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rdy;
      logic        hlt;
      logic        rdr;
      logic [9:0]  rpc;
      logic        valid;
      logic [9:0]  opc;
      logic [19:0] inst;
      logic [1:0]  lvl;
      logic [9:0]  npc;
   } vec_t;

   vec_t vec [18];

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string tag,
                          input logic v,
                          input logic [9:0] opc,
                          input logic [19:0] inst,
                          input logic [1:0] lvl,
                          input logic [9:0] npc);
      chk({tag, ".valid"}, 32'(dec_if.out_valid), 32'(v));
      chk({tag, ".out_pc"}, 32'(dec_if.out_pc), 32'(opc));
      chk({tag, ".inst"}, 32'(dec_if.out_inst), 32'(inst));
      chk({tag, ".level"}, 32'(level), 32'(lvl));
      chk({tag, ".pc"}, 32'(pc), 32'(npc));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      chk_out("reset", 1'b0, 10'd0, 20'h0, 2'd0, 10'd0);
      rst_n = 1'b1;
   endtask

   task automatic run_seq1(input string tag);
      dec_if.out_ready = 1'b1;
      tick();
      chk_out({tag, "0"}, 1'b1, 10'd0, 20'h01234, 2'd1, 10'd1);
      tick();
      chk_out({tag, "1"}, 1'b1, 10'd1, 20'h56789, 2'd1, 10'd2);
      tick();
      chk_out({tag, "2"}, 1'b1, 10'd2, 20'hABCDE, 2'd1, 10'd3);
      tick();
      chk_out({tag, "3"}, 1'b1, 10'd3, 20'hF06CC, 2'd1, 10'd4);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 1024; i++) begin
         mem[i] = {10'(i), ~10'(i)};
      end
      mem[0]    = 20'h01234;
      mem[1]    = 20'h56789;
      mem[2]    = 20'hABCDE;
      mem[3]    = 20'hF06CC;
      mem[1023] = 20'h00FFF;

      // rdy hlt rdr rpc | valid opc inst lvl npc
      vec[0]  = '{1,0,0,  0, 1,   0,20'h01234,1,   1};
      vec[1]  = '{1,0,0,  0, 1,   1,20'h56789,1,   2};
      vec[2]  = '{1,0,0,  0, 1,   2,20'hABCDE,1,   3};
      vec[3]  = '{1,0,0,  0, 1,   3,20'hF06CC,1,   4};
      vec[4]  = '{0,0,0,  0, 1,   3,20'hF06CC,2,   5};
      vec[5]  = '{0,0,1,  3, 0,   0,20'h00000,0,   3};
      vec[6]  = '{0,0,0,  0, 1,   3,20'hF06CC,1,   4};
      vec[7]  = '{0,0,0,  0, 1,   3,20'hF06CC,2,   5};
      vec[8]  = '{1,1,0,  0, 1,   4,20'h013FB,1,   5};
      vec[9]  = '{1,1,0,  0, 0,   0,20'h00000,0,   5};
      vec[10] = '{1,1,0,  0, 0,   0,20'h00000,0,   5};
      vec[11] = '{1,0,0,  0, 1,   5,20'h017FA,1,   6};
      vec[12] = '{1,0,1,1023,0,   0,20'h00000,0,1023};
      vec[13] = '{1,0,0,  0, 1,1023,20'h00FFF,1,   0};
      vec[14] = '{1,0,0,  0, 1,   0,20'h01234,1,   1};
      vec[15] = '{1,1,1,  2, 0,   0,20'h00000,0,   2};
      vec[16] = '{0,1,0,  0, 0,   0,20'h00000,0,   2};
      vec[17] = '{1,0,0,  0, 1,   2,20'hABCDE,1,   3};

      rst_n            = 1'b0;
      redirect         = 1'b0;
      redirect_pc      = '0;
      halt             = 1'b0;
      dec_if.out_ready = 1'b1;
      #2;
      do_reset();

      for (int i = 0; i < 18; i++) begin
         dec_if.out_ready = vec[i].rdy;
         halt             = vec[i].hlt;
         redirect         = vec[i].rdr;
         redirect_pc      = vec[i].rpc;
         tick();
         chk_out($sformatf("vec%0d", i), vec[i].valid,
                 vec[i].opc, vec[i].inst, vec[i].lvl,
                 vec[i].npc);
      end
      halt     = 1'b0;
      redirect = 1'b0;

      // Back-pressure straight out of reset
      dec_if.out_ready = 1'b0;
      do_reset();
      tick();
      chk_out("bp1", 1'b1, 10'd0, 20'h01234, 2'd1, 10'd1);
      tick();
      chk_out("bp2", 1'b1, 10'd0, 20'h01234, 2'd2, 10'd2);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out($sformatf("bph%0d", i), 1'b1, 10'd0,
                 20'h01234, 2'd2, 10'd2);
      end
      dec_if.out_ready = 1'b1;
      tick();
      chk_out("bpr1", 1'b1, 10'd1, 20'h56789, 2'd2, 10'd3);
      tick();
      chk_out("bpr2", 1'b1, 10'd2, 20'hABCDE, 2'd2, 10'd4);
      tick();
      chk_out("bpr3", 1'b1, 10'd3, 20'hF06CC, 2'd2, 10'd5);

      // Async reset mid-stream, between edges
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("arst", 1'b0, 10'd0, 20'h0, 2'd0, 10'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      run_seq1("again");

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
